mem_arbiter_rr: RTL and testbench
=================================

Name: mem_arbiter_rr

Overview:
Parametrised N-channel arbiter between byte-serial memory and its requesters (instruction fetch, LSB load, LSB store, future DMA/cache-refill). Replaces fixed 3-way rotating-priority allocation with true round-robin over NUM_CH channels, per-channel read/write mode, and variable transfer length up to DATA_W/8 bytes. Sits between the front-end/LSB and the single 8-bit RAM port; owns mem_a_out/mem_dout_out/mem_wr_out exclusively.

Parameters:
NUM_CH, 3, number of requester channels (>=2)
ADDR_W, 32, byte address width
DATA_W, 32, max transfer width in bits; MAXB = DATA_W/8 bytes
LEN_W, 2, width of length field; length encodes bytes-1 (0..MAXB-1)

Ports:
clk_in  in  1  sole clock, rising edge
rst_n_in  in  1  reset; one clock; reset is asynchronous and active-low
rdy_in  in  1  global enable; when 0 all state holds, all outputs hold
flush_in  in  1  branch-mispredict clear; aborts read transactions
req_in  in  NUM_CH  per-channel request level, held until done_out
wr_in  in  NUM_CH  per-channel mode: 1 write, 0 read
addr_in  in  NUM_CH*ADDR_W  per-channel start address (channel c at [c*ADDR_W +: ADDR_W])
len_in  in  NUM_CH*LEN_W  per-channel bytes-1
wdata_in  in  NUM_CH*DATA_W  per-channel write data, little-endian
gnt_out  out  NUM_CH  one-hot, one-cycle pulse on grant
done_out  out  NUM_CH  one-hot, one-cycle pulse on completion
rdata_out  out  DATA_W  assembled read data, valid with done_out, zero-extended
mem_din_in  in  8  RAM read byte (returns 1 cycle after address)
mem_a_out  out  ADDR_W  RAM byte address
mem_dout_out  out  8  RAM write byte
mem_wr_out  out  1  RAM write strobe

Behaviour:
- Reset: state=IDLE, rr pointer=0, gnt_out=0, done_out=0, rdata_out=0, mem_a_out=0, mem_dout_out=0, mem_wr_out=0.
- States: IDLE, ISSUE, DRAIN. Byte counters issue_cnt, recv_cnt (LEN_W+1 bits).
- IDLE: if any req_in, pick first requesting channel at or after rr pointer (wrapping mod NUM_CH); register gnt_out[c]=1, latch owner c, issue byte 0 same edge (mem_a_out=addr; write: mem_wr_out=1, mem_dout_out=wdata[7:0]); rr pointer <= (c+1) mod NUM_CH; -> ISSUE if len>0, else (read) DRAIN / (write) completion.
- ISSUE: one byte per cycle, byte k at addr+k; write byte k = wdata[8k+:8]. After byte len issued: read -> DRAIN, write -> done_out[c]=1 next edge, mem_wr_out=0, -> IDLE.
- Read receive: byte k captured from mem_din_in one cycle after its address; upper bytes beyond len zeroed. DRAIN ends when byte len captured: rdata_out and done_out[c] valid same cycle, -> IDLE.
- Latency (rdy_in=1): read of len L: done_out L+2 cycles after gnt_out edge; write: done_out L+1 cycles after gnt_out.
- Idle bus: mem_a_out=0, mem_wr_out=0 whenever no byte issued.
- flush_in=1 with read owner: abort, no done_out, counters cleared, -> IDLE next edge; no grant in flush cycle. Write owner: ignored, write completes (store already committed).
- flush_in in IDLE: no grant that cycle.
- Address wrap at 2^ADDR_W is modulo.
- Requester dropping req_in mid-transaction is illegal; arbiter ignores req_in after grant.
- Reset mid-transaction: immediate abort, outputs to reset values.

Optional Feature:
ARB_B2B_EN: defined -> when a read enters DRAIN, arbiter may grant the next write-free or read request in the same cycle it finishes issuing (overlapping issue with last receive), saving 1 cycle per back-to-back read; receive path tracks previous owner separately. Undefined -> next grant only from IDLE, one dead cycle between transactions.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE/ISSUE/DRAIN), BYTE_W=8, MAXB function, channel index width CH_W=$clog2(NUM_CH).
- Sub-module rr_picker: combinational rotate-priority selector (req vector, pointer -> one-hot grant, index, valid); reused by future arbiters.

Test Plan:
- Single read ch1, addr 0x100, len 3, RAM bytes 11,22,33,44 -> gnt_out=3'b010, mem_a_out 0x100..0x103 consecutive, done_out[1] 5 cycles later, rdata_out=0x44332211.
- Write ch2 addr 0x20, len 1, wdata 0xAABBCCDD -> mem_wr_out 2 cycles, bytes DD@0x20, CC@0x21, done_out[2] 2 cycles after gnt.
- All three req held continuously, len 0 -> grant order 0,1,2,0,1,2; none starved.
- flush_in during read ch0 byte 2 -> no done_out[0], mem bus idle next cycle, next grant goes to ch1.
- flush_in during write -> all 4 bytes still written, done_out pulses.
- rdy_in low 3 cycles mid-read -> counters/addresses frozen, final rdata_out unchanged vs. uninterrupted run.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the round-robin memory arbiter.
package mem_arb_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } arb_state_t;

  function automatic int unsigned maxb(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

  function automatic int unsigned ch_w(input int unsigned num_ch);
    return (num_ch < 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational rotate-priority selector: first requester at or after ptr, wrapping.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   idx,
  output logic              valid
);

  always_comb begin
    int unsigned j;
    j     = 0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      j = 32'(ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!valid && req[CH_W'(j)]) begin
        valid          = 1'b1;
        gnt[CH_W'(j)]  = 1'b1;
        idx            = CH_W'(j);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-channel round-robin arbiter onto the byte-serial RAM port.
// Optional macro ARB_B2B_EN: grant the next request on the edge that completes a read.
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic [NUM_CH-1:0]        req_in,
  input  logic [NUM_CH-1:0]        wr_in,
  input  logic [NUM_CH*ADDR_W-1:0] addr_in,
  input  logic [NUM_CH*LEN_W-1:0]  len_in,
  input  logic [NUM_CH*DATA_W-1:0] wdata_in,
  output logic [NUM_CH-1:0]        gnt_out,
  output logic [NUM_CH-1:0]        done_out,
  output logic [DATA_W-1:0]        rdata_out,
  input  logic [BYTE_W-1:0]        mem_din_in,
  output logic [ADDR_W-1:0]        mem_a_out,
  output logic [BYTE_W-1:0]        mem_dout_out,
  output logic                     mem_wr_out
);

  localparam int unsigned CH_W  = ch_w(NUM_CH);
  localparam int unsigned CNT_W = LEN_W + 1;

  arb_state_t          state, state_nx;
  logic [CH_W-1:0]     rr_ptr, rr_ptr_nx, owner, owner_nx;
  logic                owner_wr, owner_wr_nx;
  logic [LEN_W-1:0]    owner_len, owner_len_nx;
  logic [ADDR_W-1:0]   owner_addr, owner_addr_nx;
  logic [DATA_W-1:0]   owner_wdata, owner_wdata_nx;
  logic [CNT_W-1:0]    issue_cnt, issue_cnt_nx, recv_cnt, recv_cnt_nx;
  logic                rd_v1, rd_v1_nx, rd_v2, rd_v2_nx;
  logic [DATA_W-1:0]   rx_buf, rx_buf_nx, rdata_nx;
  logic [NUM_CH-1:0]   gnt_nx, done_nx;
  logic [ADDR_W-1:0]   mem_a_nx;
  logic [BYTE_W-1:0]   mem_dout_nx;
  logic                mem_wr_nx;

  logic [NUM_CH-1:0]   pick_gnt;
  logic [CH_W-1:0]     pick_idx;
  logic                pick_valid;
  logic                try_grant;
  logic [CNT_W-1:0]    len_ext;
  logic [ADDR_W-1:0]   byte_addr, sel_addr;
  logic [LEN_W-1:0]    sel_len;
  logic [DATA_W-1:0]   sel_wdata;

  rr_picker #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
    .req   (req_in),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign len_ext   = {1'b0, owner_len};
  assign byte_addr = owner_addr + ADDR_W'(issue_cnt);
  assign sel_addr  = addr_in[pick_idx*ADDR_W +: ADDR_W];
  assign sel_len   = len_in[pick_idx*LEN_W +: LEN_W];
  assign sel_wdata = wdata_in[pick_idx*DATA_W +: DATA_W];

  always_comb begin
    state_nx       = state;
    rr_ptr_nx      = rr_ptr;
    owner_nx       = owner;
    owner_wr_nx    = owner_wr;
    owner_len_nx   = owner_len;
    owner_addr_nx  = owner_addr;
    owner_wdata_nx = owner_wdata;
    issue_cnt_nx   = issue_cnt;
    recv_cnt_nx    = recv_cnt;
    rx_buf_nx      = rx_buf;
    rd_v1_nx       = 1'b0;
    rd_v2_nx       = rd_v1;
    gnt_nx         = '0;
    done_nx        = '0;
    rdata_nx       = rdata_out;
    mem_a_nx       = '0;
    mem_dout_nx    = '0;
    mem_wr_nx      = 1'b0;
    try_grant      = 1'b0;

    // rd_v2 marks the cycle in which a read byte issued two edges ago sits on mem_din_in
    if (rd_v2) begin
      rx_buf_nx   = rx_buf | (DATA_W'(mem_din_in) << {recv_cnt, 3'b000});
      recv_cnt_nx = recv_cnt + CNT_W'(1);
    end

    case (state)
      IDLE: try_grant = !flush_in;
      ISSUE: begin
        if (owner_wr) begin
          if (issue_cnt == len_ext + CNT_W'(1)) begin
            done_nx[owner] = 1'b1;
            state_nx       = IDLE;
          end else begin
            mem_a_nx     = byte_addr;
            mem_wr_nx    = 1'b1;
            mem_dout_nx  = BYTE_W'(owner_wdata >> {issue_cnt, 3'b000});
            issue_cnt_nx = issue_cnt + CNT_W'(1);
          end
        end else if (flush_in) begin
          state_nx     = IDLE;
          issue_cnt_nx = '0;
          recv_cnt_nx  = '0;
          rd_v2_nx     = 1'b0;
        end else begin
          mem_a_nx     = byte_addr;
          rd_v1_nx     = 1'b1;
          issue_cnt_nx = issue_cnt + CNT_W'(1);
          if (issue_cnt == len_ext) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (flush_in) begin
          state_nx     = IDLE;
          issue_cnt_nx = '0;
          recv_cnt_nx  = '0;
          rd_v2_nx     = 1'b0;
        end else if (rd_v2 && recv_cnt == len_ext) begin
          done_nx[owner] = 1'b1;
          rdata_nx       = rx_buf_nx;
          state_nx       = IDLE;
`ifdef ARB_B2B_EN
          try_grant      = 1'b1;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase

    // done/rdata above already use the outgoing owner, so a same-edge grant may reload it
    if (try_grant && pick_valid) begin
      gnt_nx         = pick_gnt;
      owner_nx       = pick_idx;
      owner_wr_nx    = wr_in[pick_idx];
      owner_len_nx   = sel_len;
      owner_addr_nx  = sel_addr;
      owner_wdata_nx = sel_wdata;
      rr_ptr_nx      = (32'(pick_idx) == NUM_CH - 1) ? '0 : pick_idx + CH_W'(1);
      issue_cnt_nx   = CNT_W'(1);
      recv_cnt_nx    = '0;
      rx_buf_nx      = '0;
      mem_a_nx       = sel_addr;
      if (wr_in[pick_idx]) begin
        mem_wr_nx   = 1'b1;
        mem_dout_nx = BYTE_W'(sel_wdata);
        state_nx    = ISSUE;
      end else begin
        rd_v1_nx = 1'b1;
        state_nx = (sel_len == '0) ? DRAIN : ISSUE;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      owner_wr     <= 1'b0;
      owner_len    <= '0;
      owner_addr   <= '0;
      owner_wdata  <= '0;
      issue_cnt    <= '0;
      recv_cnt     <= '0;
      rd_v1        <= 1'b0;
      rd_v2        <= 1'b0;
      rx_buf       <= '0;
      gnt_out      <= '0;
      done_out     <= '0;
      rdata_out    <= '0;
      mem_a_out    <= '0;
      mem_dout_out <= '0;
      mem_wr_out   <= 1'b0;
    end else if (rdy_in) begin
      state        <= state_nx;
      rr_ptr       <= rr_ptr_nx;
      owner        <= owner_nx;
      owner_wr     <= owner_wr_nx;
      owner_len    <= owner_len_nx;
      owner_addr   <= owner_addr_nx;
      owner_wdata  <= owner_wdata_nx;
      issue_cnt    <= issue_cnt_nx;
      recv_cnt     <= recv_cnt_nx;
      rd_v1        <= rd_v1_nx;
      rd_v2        <= rd_v2_nx;
      rx_buf       <= rx_buf_nx;
      gnt_out      <= gnt_nx;
      done_out     <= done_nx;
      rdata_out    <= rdata_nx;
      mem_a_out    <= mem_a_nx;
      mem_dout_out <= mem_dout_nx;
      mem_wr_out   <= mem_wr_nx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed self-checking bench for mem_arbiter_rr with a registered byte RAM model.
module tb_mem_arbiter_rr;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 2;

  logic                     clk_in = 1'b0;
  logic                     rst_n_in;
  logic                     rdy_in;
  logic                     flush_in;
  logic [NUM_CH-1:0]        req_in;
  logic [NUM_CH-1:0]        wr_in;
  logic [NUM_CH*ADDR_W-1:0] addr_in;
  logic [NUM_CH*LEN_W-1:0]  len_in;
  logic [NUM_CH*DATA_W-1:0] wdata_in;
  logic [NUM_CH-1:0]        gnt_out;
  logic [NUM_CH-1:0]        done_out;
  logic [DATA_W-1:0]        rdata_out;
  logic [7:0]               mem_din_in;
  logic [ADDR_W-1:0]        mem_a_out;
  logic [7:0]               mem_dout_out;
  logic                     mem_wr_out;

  logic [7:0] rom  [4096];
  logic [7:0] wmem [4096];
  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter_rr #(
    .NUM_CH(NUM_CH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .rdy_in      (rdy_in),
    .flush_in    (flush_in),
    .req_in      (req_in),
    .wr_in       (wr_in),
    .addr_in     (addr_in),
    .len_in      (len_in),
    .wdata_in    (wdata_in),
    .gnt_out     (gnt_out),
    .done_out    (done_out),
    .rdata_out   (rdata_out),
    .mem_din_in  (mem_din_in),
    .mem_a_out   (mem_a_out),
    .mem_dout_out(mem_dout_out),
    .mem_wr_out  (mem_wr_out)
  );

  always #5 clk_in = ~clk_in;

  // RAM shares the global enable so a stalled read sees the same byte stream
  always @(posedge clk_in) begin
    if (rdy_in) begin
      mem_din_in <= rom[mem_a_out[11:0]];
      if (mem_wr_out) wmem[mem_a_out[11:0]] <= mem_dout_out;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_ch(input int c, input logic w, input logic [31:0] a,
                        input logic [1:0] l, input logic [31:0] d);
    wr_in[c]                    = w;
    addr_in[c*ADDR_W +: ADDR_W] = a;
    len_in[c*LEN_W +: LEN_W]    = l;
    wdata_in[c*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rr_byte [3];
    rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
    req_in = '0; wr_in = '0; addr_in = '0; len_in = '0; wdata_in = '0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h100] = 8'h11; rom[12'h101] = 8'h22; rom[12'h102] = 8'h33; rom[12'h103] = 8'h44;
    rom[12'h200] = 8'h5A; rom[12'h300] = 8'hA5; rom[12'h400] = 8'h3C;
    rom[12'hFFF] = 8'h77; rom[12'h000] = 8'h66;
    rr_byte[0] = 8'h5A; rr_byte[1] = 8'hA5; rr_byte[2] = 8'h3C;

    repeat (2) @(posedge clk_in);
    #1;
    check_eq("rst_gnt", gnt_out, 0);
    check_eq("rst_done", done_out, 0);
    check_eq("rst_rdata", rdata_out, 0);
    check_eq("rst_mem_a", mem_a_out, 0);
    check_eq("rst_mem_wr", mem_wr_out, 0);
    check_eq("rst_mem_dout", mem_dout_out, 0);
    rst_n_in = 1'b1;
    tick();
    check_eq("idle_gnt", gnt_out, 0);

    // single read ch1, 4 bytes
    set_ch(1, 1'b0, 32'h100, 2'd3, 32'h0); req_in = 3'b010;
    tick();
    check_eq("rd_gnt", gnt_out, 3'b010);
    check_eq("rd_a0", mem_a_out, 32'h100);
    check_eq("rd_wr0", mem_wr_out, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq($sformatf("rd_a%0d", k), mem_a_out, 32'h100 + k);
      check_eq($sformatf("rd_nodone%0d", k), done_out, 0);
    end
    tick();
    check_eq("rd_bus_idle", mem_a_out, 0);
    check_eq("rd_done_early", done_out, 0);
    tick();
    check_eq("rd_done", done_out, 3'b010);
    check_eq("rd_data", rdata_out, 32'h44332211);
    req_in = '0;

    // write ch2, 2 bytes
    set_ch(2, 1'b1, 32'h20, 2'd1, 32'hAABBCCDD); req_in = 3'b100;
    tick();
    check_eq("wr_gnt", gnt_out, 3'b100);
    check_eq("wr_a0", mem_a_out, 32'h20);
    check_eq("wr_d0", mem_dout_out, 8'hDD);
    check_eq("wr_we0", mem_wr_out, 1);
    tick();
    check_eq("wr_a1", mem_a_out, 32'h21);
    check_eq("wr_d1", mem_dout_out, 8'hCC);
    check_eq("wr_we1", mem_wr_out, 1);
    tick();
    check_eq("wr_we_off", mem_wr_out, 0);
    check_eq("wr_done", done_out, 3'b100);
    req_in = '0;
    tick();
    check_eq("wr_mem20", wmem[12'h020], 8'hDD);
    check_eq("wr_mem21", wmem[12'h021], 8'hCC);

    // all channels held, single-byte reads: grants every 3 cycles in order 0,1,2,0,1,2
    set_ch(0, 1'b0, 32'h200, 2'd0, 32'h0);
    set_ch(1, 1'b0, 32'h300, 2'd0, 32'h0);
    set_ch(2, 1'b0, 32'h400, 2'd0, 32'h0);
    req_in = 3'b111;
    for (int c = 0; c < 18; c++) begin
      tick();
      check_eq($sformatf("rr_gnt_c%0d", c), gnt_out,
               (c % 3 == 0) ? (64'd1 << ((c / 3) % 3)) : 64'd0);
      check_eq($sformatf("rr_done_c%0d", c), done_out,
               (c % 3 == 2) ? (64'd1 << ((c / 3) % 3)) : 64'd0);
      if (c % 3 == 2) check_eq($sformatf("rr_data_c%0d", c), rdata_out, rr_byte[(c / 3) % 3]);
    end
    req_in = '0;

    // flush aborts read ch0 while byte 2 is on the bus
    set_ch(0, 1'b0, 32'h100, 2'd3, 32'h0);
    set_ch(1, 1'b0, 32'h300, 2'd0, 32'h0);
    req_in = 3'b001;
    tick();
    check_eq("fl_gnt0", gnt_out, 3'b001);
    tick();
    tick();
    check_eq("fl_a2", mem_a_out, 32'h102);
    flush_in = 1'b1; req_in = 3'b011;
    tick();
    check_eq("fl_bus_idle", mem_a_out, 0);
    check_eq("fl_no_gnt", gnt_out, 0);
    check_eq("fl_no_done", done_out, 0);
    flush_in = 1'b0;
    tick();
    check_eq("fl_next_gnt", gnt_out, 3'b010);
    check_eq("fl_next_a", mem_a_out, 32'h300);
    tick();
    check_eq("fl_wait_done", done_out, 0);
    tick();
    check_eq("fl_ch1_done", done_out, 3'b010);
    check_eq("fl_ch1_data", rdata_out, 32'h000000A5);
    req_in = '0;

    // flush during a write is ignored
    set_ch(2, 1'b1, 32'h40, 2'd3, 32'h87654321); req_in = 3'b100;
    tick();
    check_eq("fw_gnt", gnt_out, 3'b100);
    check_eq("fw_d0", mem_dout_out, 8'h21);
    flush_in = 1'b1;
    tick();
    check_eq("fw_a1", mem_a_out, 32'h41);
    check_eq("fw_d1", mem_dout_out, 8'h43);
    tick();
    check_eq("fw_d2", mem_dout_out, 8'h65);
    tick();
    check_eq("fw_a3", mem_a_out, 32'h43);
    check_eq("fw_d3", mem_dout_out, 8'h87);
    check_eq("fw_we3", mem_wr_out, 1);
    tick();
    check_eq("fw_done", done_out, 3'b100);
    check_eq("fw_we_off", mem_wr_out, 0);
    flush_in = 1'b0; req_in = '0;
    tick();
    check_eq("fw_mem", {wmem[12'h043], wmem[12'h042], wmem[12'h041], wmem[12'h040]}, 32'h87654321);

    // rdy_in low for three cycles mid-read
    set_ch(0, 1'b0, 32'h100, 2'd3, 32'h0); req_in = 3'b001;
    tick();
    check_eq("st_gnt", gnt_out, 3'b001);
    tick();
    check_eq("st_a1", mem_a_out, 32'h101);
    rdy_in = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check_eq($sformatf("st_hold_a%0d", s), mem_a_out, 32'h101);
      check_eq($sformatf("st_hold_gnt%0d", s), gnt_out, 0);
    end
    rdy_in = 1'b1;
    tick();
    check_eq("st_a2", mem_a_out, 32'h102);
    tick();
    check_eq("st_a3", mem_a_out, 32'h103);
    tick();
    check_eq("st_no_done", done_out, 0);
    tick();
    check_eq("st_done", done_out, 3'b001);
    check_eq("st_data", rdata_out, 32'h44332211);
    req_in = '0;

    // address wraps modulo 2^ADDR_W
    set_ch(1, 1'b0, 32'hFFFF_FFFF, 2'd1, 32'h0); req_in = 3'b010;
    tick();
    check_eq("wa_gnt", gnt_out, 3'b010);
    check_eq("wa_a0", mem_a_out, 32'hFFFF_FFFF);
    tick();
    check_eq("wa_a1", mem_a_out, 32'h0);
    tick();
    check_eq("wa_no_done", done_out, 0);
    tick();
    check_eq("wa_done", done_out, 3'b010);
    check_eq("wa_data", rdata_out, 32'h00006677);
    req_in = '0;

    // asynchronous reset mid-write, then pointer restarts at channel 0
    set_ch(2, 1'b1, 32'h80, 2'd3, 32'h11223344); req_in = 3'b100;
    tick();
    check_eq("ar_gnt", gnt_out, 3'b100);
    tick();
    check_eq("ar_a1", mem_a_out, 32'h81);
    #2 rst_n_in = 1'b0;
    #1;
    check_eq("ar_we", mem_wr_out, 0);
    check_eq("ar_a", mem_a_out, 0);
    check_eq("ar_dout", mem_dout_out, 0);
    req_in = '0;
    tick();
    rst_n_in = 1'b1;
    tick();
    check_eq("ar_idle_gnt", gnt_out, 0);
    req_in = 3'b101;
    tick();
    check_eq("ar_ptr_reset", gnt_out, 3'b001);
    req_in = '0;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
